// File: rtl/cw_sequencer_if.sv
// rtl/cw_sequencer_if.sv - sequencer bus: fetch handshake, decoder words/constants, datapath outputs
interface cw_sequencer_if;
    logic        run;
    logic        mem_ready;
    logic [31:0] databus;
    logic [32:0] cw_br;
    logic [32:0] cw_b;
    logic [32:0] cw_cb;
    logic [32:0] cw_mem;
    logic [32:0] cw_alu;
    logic [63:0] k_br;
    logic [63:0] k_b;
    logic [63:0] k_cb;
    logic [63:0] k_mem;
    logic [63:0] k_alu;
    logic [31:0] I_out;
    logic [1:0]  phase;
    logic [32:0] cw_out;
    logic [63:0] K_out;
    logic        ir_ld;
    logic        halted;
    logic [31:0] retired_count;

    modport master (
        output run, mem_ready, databus,
        output cw_br, cw_b, cw_cb, cw_mem, cw_alu,
        output k_br, k_b, k_cb, k_mem, k_alu,
        input  I_out, phase, cw_out, K_out, ir_ld, halted, retired_count
    );

    modport slave (
        input  run, mem_ready, databus,
        input  cw_br, cw_b, cw_cb, cw_mem, cw_alu,
        input  k_br, k_b, k_cb, k_mem, k_alu,
        output I_out, phase, cw_out, K_out, ir_ld, halted, retired_count
    );
endinterface

// File: rtl/cw_sequencer.sv
// rtl/cw_sequencer.sv - LEGv8 fetch/execute sequencer; define RETIRE_CNT_EN to enable retired_count
module cw_sequencer #(
    parameter int MAX_EXEC_CYCLES = 4,
    parameter int MEM_TIMEOUT     = 16
) (
    input  logic          clock,
    input  logic          reset,
    cw_sequencer_if.slave bus
);
    localparam int EXEC_W  = $clog2(MAX_EXEC_CYCLES + 1);
    localparam int STALL_W = $clog2(MEM_TIMEOUT + 1);

    // alu_fs=11111 and rf_sb=31, everything else idle
    localparam logic [32:0] CW_SAFE    = 33'h0_7C0F_8000;
    // SAFE plus ram_en and pc_fs=PC+4
    localparam logic [32:0] CW_FETCH   = 33'h0_7C0F_8110;
    // clears rf_w, ram_w, pc_en, pc_fs and status_ld while RAM is not ready
    localparam logic [32:0] STALL_KEEP = 33'h1_FFFF_FD0B;

    typedef enum logic [1:0] {S_FETCH = 2'd0, S_EXEC = 2'd1, S_FAULT = 2'd2} state_t;
    typedef enum logic [2:0] {C_BR, C_B, C_CB, C_MEM, C_ALU} cls_t;

    state_t               state_q, state_d;
    cls_t                 cls;
    logic [31:0]          ir_q, ir_d;
    logic [1:0]           phase_q, phase_d;
    logic [EXEC_W-1:0]    exec_cnt_q, exec_cnt_d, exec_inc;
    logic [STALL_W-1:0]   stall_cnt_q, stall_cnt_d, stall_inc;
    logic [10:0]          op;
    logic [32:0]          sel_cw;
    logic [63:0]          sel_k;
    logic [32:0]          issued;
    logic                 stall;

    assign op        = ir_q[31:21];
    assign stall     = issued[8] && !bus.mem_ready;
    assign exec_inc  = exec_cnt_q + EXEC_W'(1);
    assign stall_inc = stall_cnt_q + STALL_W'(1);

    // Classify the held instruction by opcode, first match wins
    always_comb begin
        cls = C_ALU;
        if (op == 11'b11010110000)
            cls = C_BR;
        else if (op[10:5] == 6'b000101)
            cls = C_B;
        else if (op[10:3] == 8'b10110100 || op[10:3] == 8'b10110101 || op[10:3] == 8'b01010100)
            cls = C_CB;
        else if (op == 11'b11111000000 || op == 11'b11111000010)
            cls = C_MEM;
    end

    // Route the chosen decoder's control word and constant
    always_comb begin
        sel_cw = bus.cw_alu;
        sel_k  = bus.k_alu;
        case (cls)
            C_BR:    begin sel_cw = bus.cw_br;  sel_k = bus.k_br;  end
            C_B:     begin sel_cw = bus.cw_b;   sel_k = bus.k_b;   end
            C_CB:    begin sel_cw = bus.cw_cb;  sel_k = bus.k_cb;  end
            C_MEM:   begin sel_cw = bus.cw_mem; sel_k = bus.k_mem; end
            default: begin sel_cw = bus.cw_alu; sel_k = bus.k_alu; end
        endcase
    end

    // Word issued this cycle before any stall masking
    always_comb begin
        issued = CW_SAFE;
        if (state_q == S_EXEC)
            issued = sel_cw;
        else if (state_q == S_FETCH && bus.run)
            issued = CW_FETCH;
    end

    assign bus.cw_out = stall ? (issued & STALL_KEEP) : issued;
    assign bus.K_out  = (state_q == S_EXEC) ? sel_k : 64'd0;
    assign bus.ir_ld  = (state_q == S_FETCH) && bus.run && bus.mem_ready;
    assign bus.halted = (state_q == S_FAULT);
    assign bus.I_out  = ir_q;
    assign bus.phase  = phase_q;

    // Next state: stalls freeze everything but the stall counter; otherwise fetch/execute/retire
    always_comb begin
        state_d     = state_q;
        ir_d        = ir_q;
        phase_d     = phase_q;
        exec_cnt_d  = exec_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (stall) begin
            stall_cnt_d = stall_inc;
            if (stall_inc >= STALL_W'(MEM_TIMEOUT))
                state_d = S_FAULT;
        end else begin
            stall_cnt_d = '0;
            case (state_q)
                S_FETCH: begin
                    if (bus.run && bus.mem_ready) begin
                        state_d    = S_EXEC;
                        ir_d       = bus.databus;
                        phase_d    = 2'd0;
                        exec_cnt_d = '0;
                    end
                end
                S_EXEC: begin
                    if (issued[1:0] == 2'b00) begin
                        state_d = S_FETCH;
                    end else if (exec_inc >= EXEC_W'(MAX_EXEC_CYCLES)) begin
                        state_d = S_FAULT;
                    end else begin
                        phase_d    = issued[1:0];
                        exec_cnt_d = exec_inc;
                    end
                end
                default: state_d = S_FAULT;
            endcase
        end
    end

    // State, instruction register and watchdog counters
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_FETCH;
            ir_q        <= 32'd0;
            phase_q     <= 2'd0;
            exec_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            ir_q        <= ir_d;
            phase_q     <= phase_d;
            exec_cnt_q  <= exec_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

`ifdef RETIRE_CNT_EN
    logic        retire;
    logic [31:0] retired_q;

    assign retire = (state_q == S_EXEC) && !stall && (issued[1:0] == 2'b00);

    // Count retirements, wrapping naturally at 32 bits
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            retired_q <= 32'd0;
        else if (retire)
            retired_q <= retired_q + 32'd1;
    end

    assign bus.retired_count = retired_q;
`else
    assign bus.retired_count = 32'd0;
`endif
endmodule

// File: tb/tb_cw_sequencer.sv
// tb/tb_cw_sequencer.sv - self-checking bench for cw_sequencer
module tb_cw_sequencer;
    localparam logic [32:0] SAFE    = 33'h0_7C0F_8000;
    localparam logic [32:0] FETCH_W = 33'h0_7C0F_8110;
    localparam logic [32:0] KEEP    = 33'h1_FFFF_FD0B;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    logic [32:0] cw_tab [5][4];
    logic [63:0] k_tab  [5][4];

    cw_sequencer_if bus ();

    cw_sequencer dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Decoders: each class's word/constant is a table lookup on the presented phase
    always_comb begin
        bus.cw_br  = cw_tab[0][bus.phase];
        bus.cw_b   = cw_tab[1][bus.phase];
        bus.cw_cb  = cw_tab[2][bus.phase];
        bus.cw_mem = cw_tab[3][bus.phase];
        bus.cw_alu = cw_tab[4][bus.phase];
        bus.k_br   = k_tab[0][bus.phase];
        bus.k_b    = k_tab[1][bus.phase];
        bus.k_cb   = k_tab[2][bus.phase];
        bus.k_mem  = k_tab[3][bus.phase];
        bus.k_alu  = k_tab[4][bus.phase];
    end

    function automatic logic [10:0] make_op(input int cls);
        logic [7:0]  cb  [3];
        logic [10:0] alu [5];
        cb  = '{8'b10110100, 8'b10110101, 8'b01010100};
        alu = '{11'b10001011000, 11'b11001011000, 11'b10001010000, 11'b10101010000, 11'b11001010000};
        case (cls)
            0:       return 11'b11010110000;
            1:       return {6'b000101, 5'($urandom)};
            2:       return {cb[$urandom_range(2)], 3'($urandom)};
            3:       return ($urandom_range(1) == 1) ? 11'b11111000010 : 11'b11111000000;
            default: return alu[$urandom_range(4)];
        endcase
    endfunction

    // Random decoder tables where each class walks phases 0..nph-1 then retires
    task automatic fill_tables(input int nph);
        for (int c = 0; c < 5; c++) begin
            for (int p = 0; p < 4; p++) begin
                cw_tab[c][p]      = {1'($urandom), 32'($urandom)};
                cw_tab[c][p][1:0] = (p < nph - 1) ? 2'(p + 1) : 2'd0;
                k_tab[c][p]       = {32'($urandom), 32'($urandom)};
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        bus.run       = 1'b0;
        bus.mem_ready = 1'b0;
        bus.databus   = 32'd0;
        reset = 1'b1;
        #1 reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clock);
        bus.run = 1'b0; bus.mem_ready = 1'b1; bus.databus = 32'hFFFF_FFFF;
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({bus.I_out, bus.phase, bus.cw_out, bus.K_out, bus.ir_ld, bus.halted, bus.retired_count}
            !== {32'd0, 2'd0, SAFE, 64'd0, 1'b0, 1'b0, 32'd0}) begin
            n_err++;
            $display("FAIL reset_values: I_out=%h phase=%0d cw=%h K=%h ir_ld=%b halted=%b ret=%0d, want zeros with SAFE",
                     bus.I_out, bus.phase, bus.cw_out, bus.K_out, bus.ir_ld, bus.halted, bus.retired_count);
        end
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_br();
        do_reset();
        fill_tables(1);
        @(negedge clock);
        bus.run = 1'b1; bus.mem_ready = 1'b1; bus.databus = 32'hD61F_0000;
        #1;
        n_cmp++;
        if ({bus.cw_out, bus.K_out, bus.ir_ld} !== {FETCH_W, 64'd0, 1'b1}) begin
            n_err++;
            $display("FAIL br_fetch: cw=%h K=%h ir_ld=%b want cw=%h K=0 ir_ld=1", bus.cw_out, bus.K_out, bus.ir_ld, FETCH_W);
        end
        @(negedge clock);
        bus.databus = 32'h1234_5678;
        #1;
        n_cmp++;
        if ({bus.I_out, bus.phase, bus.cw_out, bus.K_out, bus.ir_ld} !== {32'hD61F_0000, 2'd0, cw_tab[0][0], k_tab[0][0], 1'b0}) begin
            n_err++;
            $display("FAIL br_exec: I=%h ph=%0d cw=%h K=%h want I=d61f0000 ph=0 cw=%h K=%h",
                     bus.I_out, bus.phase, bus.cw_out, bus.K_out, cw_tab[0][0], k_tab[0][0]);
        end
        @(negedge clock);
        #1;
        n_cmp++;
        if ({bus.cw_out, bus.K_out, bus.ir_ld, bus.halted} !== {FETCH_W, 64'd0, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL br_refetch: cw=%h K=%h ir_ld=%b want cw=%h", bus.cw_out, bus.K_out, bus.ir_ld, FETCH_W);
        end
    endtask

    task automatic test_ldur_stall();
        logic [31:0] ins;
        do_reset();
        fill_tables(2);
        cw_tab[3][0][8]   = 1'b0;
        cw_tab[3][1][8]   = 1'b1;
        cw_tab[3][1][9]   = 1'b1;
        cw_tab[3][1][5:4] = 2'b11;
        ins = {11'b11111000010, 21'($urandom)};
        @(negedge clock);
        bus.run = 1'b1; bus.mem_ready = 1'b1; bus.databus = ins;
        @(negedge clock);
        #1;
        n_cmp++;
        if ({bus.I_out, bus.phase, bus.cw_out, bus.K_out} !== {ins, 2'd0, cw_tab[3][0], k_tab[3][0]}) begin
            n_err++;
            $display("FAIL ldur_phase0: I=%h ph=%0d cw=%h want I=%h ph=0 cw=%h", bus.I_out, bus.phase, bus.cw_out, ins, cw_tab[3][0]);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            bus.mem_ready = 1'b0;
            #1;
            n_cmp++;
            if ({bus.I_out, bus.phase, bus.cw_out, bus.ir_ld} !== {ins, 2'd1, cw_tab[3][1] & KEEP, 1'b0}) begin
                n_err++;
                $display("FAIL ldur_stall%0d: I=%h ph=%0d cw=%h want ph=1 cw=%h", i, bus.I_out, bus.phase, bus.cw_out, cw_tab[3][1] & KEEP);
            end
            n_cmp++;
            if ({bus.cw_out[9], bus.cw_out[5:4]} !== 3'b000) begin
                n_err++;
                $display("FAIL ldur_stall_bits%0d: rf_w=%b pc_fs=%b want 0 00", i, bus.cw_out[9], bus.cw_out[5:4]);
            end
        end
        @(negedge clock);
        bus.mem_ready = 1'b1;
        #1;
        n_cmp++;
        if ({bus.phase, bus.cw_out} !== {2'd1, cw_tab[3][1]}) begin
            n_err++;
            $display("FAIL ldur_complete: ph=%0d cw=%h want ph=1 cw=%h", bus.phase, bus.cw_out, cw_tab[3][1]);
        end
        @(negedge clock);
        #1;
        n_cmp++;
        if ({bus.cw_out, bus.K_out, bus.halted} !== {FETCH_W, 64'd0, 1'b0}) begin
            n_err++;
            $display("FAIL ldur_retire: cw=%h halted=%b want cw=%h halted=0", bus.cw_out, bus.halted, FETCH_W);
        end
    endtask

    task automatic test_exec_fault();
        logic [31:0] ins;
        do_reset();
        fill_tables(4);
        for (int p = 0; p < 4; p++) begin
            cw_tab[4][p][1:0] = 2'd1;
            cw_tab[4][p][8]   = 1'b0;
        end
        ins = {11'b10001011000, 21'($urandom)};
        @(negedge clock);
        bus.run = 1'b1; bus.mem_ready = 1'b1; bus.databus = ins;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            #1;
            n_cmp++;
            if ({bus.phase, bus.cw_out, bus.halted} !== {2'((i == 0) ? 0 : 1), cw_tab[4][(i == 0) ? 0 : 1], 1'b0}) begin
                n_err++;
                $display("FAIL exec_cycle%0d: ph=%0d cw=%h halted=%b", i, bus.phase, bus.cw_out, bus.halted);
            end
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            #1;
            n_cmp++;
            if ({bus.cw_out, bus.K_out, bus.ir_ld, bus.halted} !== {SAFE, 64'd0, 1'b0, 1'b1}) begin
                n_err++;
                $display("FAIL exec_fault%0d: cw=%h K=%h ir_ld=%b halted=%b want SAFE halted", i, bus.cw_out, bus.K_out, bus.ir_ld, bus.halted);
            end
        end
        do_reset();
        #1;
        n_cmp++;
        if (bus.halted !== 1'b0) begin
            n_err++;
            $display("FAIL fault_cleared: halted=%b want 0", bus.halted);
        end
    endtask

    task automatic test_fetch_timeout();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            @(negedge clock);
            bus.run = 1'b1; bus.mem_ready = 1'b0;
            #1;
            n_cmp++;
            if ({bus.cw_out, bus.ir_ld, bus.halted} !== {FETCH_W & KEEP, 1'b0, 1'b0}) begin
                n_err++;
                $display("FAIL fetch_stall%0d: cw=%h ir_ld=%b halted=%b", i, bus.cw_out, bus.ir_ld, bus.halted);
            end
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            bus.mem_ready = 1'b1;
            #1;
            n_cmp++;
            if ({bus.cw_out, bus.ir_ld, bus.halted} !== {SAFE, 1'b0, 1'b1}) begin
                n_err++;
                $display("FAIL fetch_timeout%0d: cw=%h ir_ld=%b halted=%b want SAFE 0 1", i, bus.cw_out, bus.ir_ld, bus.halted);
            end
        end
    endtask

    task automatic test_run_low();
        logic [31:0] ins;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            bus.run = 1'b0; bus.mem_ready = 1'($urandom); bus.databus = $urandom;
            #1;
            n_cmp++;
            if ({bus.cw_out, bus.I_out, bus.ir_ld} !== {SAFE, 32'd0, 1'b0}) begin
                n_err++;
                $display("FAIL run_low%0d: cw=%h I=%h ir_ld=%b want SAFE 0 0", i, bus.cw_out, bus.I_out, bus.ir_ld);
            end
        end
        ins = $urandom;
        @(negedge clock);
        bus.run = 1'b1; bus.mem_ready = 1'b1; bus.databus = ins;
        #1;
        n_cmp++;
        if ({bus.cw_out, bus.ir_ld} !== {FETCH_W, 1'b1}) begin
            n_err++;
            $display("FAIL run_rise: cw=%h ir_ld=%b want %h 1", bus.cw_out, bus.ir_ld, FETCH_W);
        end
        @(negedge clock);
        bus.run = 1'b0;
        #1;
        n_cmp++;
        if (bus.I_out !== ins) begin
            n_err++;
            $display("FAIL run_capture: I=%h want %h", bus.I_out, ins);
        end
    endtask

    task automatic test_random();
        int          cls, nph, p, exp_ret;
        logic [31:0] ins;
        logic [32:0] w;
        logic [63:0] k;
        do_reset();
        exp_ret = 0;
        for (int n = 0; n < 40; n++) begin
            cls = $urandom_range(4);
            nph = $urandom_range(4, 1);
            fill_tables(nph);
            ins = {make_op(cls), 21'($urandom)};
            for (int i = 0; i < int'($urandom_range(2)); i++) begin
                @(negedge clock);
                bus.run = 1'b0; bus.mem_ready = 1'($urandom); bus.databus = $urandom;
                #1;
                n_cmp++;
                if ({bus.cw_out, bus.K_out, bus.ir_ld, bus.halted} !== {SAFE, 64'd0, 1'b0, 1'b0}) begin
                    n_err++;
                    $display("FAIL rnd_idle n=%0d: cw=%h K=%h ir_ld=%b halted=%b", n, bus.cw_out, bus.K_out, bus.ir_ld, bus.halted);
                end
            end
            for (int i = 0; i < int'($urandom_range(3)); i++) begin
                @(negedge clock);
                bus.run = 1'b1; bus.mem_ready = 1'b0; bus.databus = $urandom;
                #1;
                n_cmp++;
                if ({bus.cw_out, bus.K_out, bus.ir_ld, bus.halted} !== {FETCH_W & KEEP, 64'd0, 1'b0, 1'b0}) begin
                    n_err++;
                    $display("FAIL rnd_fetch_stall n=%0d: cw=%h ir_ld=%b halted=%b", n, bus.cw_out, bus.ir_ld, bus.halted);
                end
            end
            @(negedge clock);
            bus.run = 1'b1; bus.mem_ready = 1'b1; bus.databus = ins;
            #1;
            n_cmp++;
            if ({bus.cw_out, bus.K_out, bus.ir_ld} !== {FETCH_W, 64'd0, 1'b1}) begin
                n_err++;
                $display("FAIL rnd_fetch n=%0d: cw=%h ir_ld=%b want %h 1", n, bus.cw_out, bus.ir_ld, FETCH_W);
            end
            p = 0;
            for (int s = 0; s < nph; s++) begin
                w = cw_tab[cls][p];
                k = k_tab[cls][p];
                if (w[8]) begin
                    for (int i = 0; i < int'($urandom_range(3)); i++) begin
                        @(negedge clock);
                        bus.run = 1'($urandom); bus.mem_ready = 1'b0; bus.databus = $urandom;
                        #1;
                        n_cmp++;
                        if ({bus.I_out, bus.phase, bus.cw_out, bus.K_out, bus.ir_ld, bus.halted}
                            !== {ins, 2'(p), w & KEEP, k, 1'b0, 1'b0}) begin
                            n_err++;
                            $display("FAIL rnd_exec_stall n=%0d cls=%0d p=%0d: I=%h ph=%0d cw=%h K=%h want I=%h cw=%h K=%h",
                                     n, cls, p, bus.I_out, bus.phase, bus.cw_out, bus.K_out, ins, w & KEEP, k);
                        end
                    end
                end
                @(negedge clock);
                bus.run = 1'($urandom); bus.databus = $urandom;
                bus.mem_ready = w[8] ? 1'b1 : 1'($urandom);
                #1;
                n_cmp++;
                if ({bus.I_out, bus.phase, bus.cw_out, bus.K_out, bus.ir_ld, bus.halted}
                    !== {ins, 2'(p), w, k, 1'b0, 1'b0}) begin
                    n_err++;
                    $display("FAIL rnd_exec n=%0d cls=%0d p=%0d: I=%h ph=%0d cw=%h K=%h want I=%h cw=%h K=%h",
                             n, cls, p, bus.I_out, bus.phase, bus.cw_out, bus.K_out, ins, w, k);
                end
                p = int'(w[1:0]);
            end
            exp_ret++;
            @(negedge clock);
            bus.run = 1'b0;
        end
        @(negedge clock);
        #1;
        n_cmp++;
`ifdef RETIRE_CNT_EN
        if (bus.retired_count !== 32'(exp_ret)) begin
`else
        if (bus.retired_count !== 32'd0) begin
`endif
            n_err++;
            $display("FAIL rnd_retired: got %0d retirements=%0d", bus.retired_count, exp_ret);
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] ins;
        do_reset();
        fill_tables(3);
        ins = {11'b10001011000, 21'($urandom)};
        @(negedge clock);
        bus.run = 1'b1; bus.mem_ready = 1'b1; bus.databus = ins;
        @(negedge clock);
        @(negedge clock);
        #1;
        n_cmp++;
        if ({bus.I_out, bus.phase} !== {ins, 2'd1}) begin
            n_err++;
            $display("FAIL async_pre: I=%h ph=%0d want %h 1", bus.I_out, bus.phase, ins);
        end
        bus.run = 1'b0;
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({bus.I_out, bus.phase, bus.cw_out, bus.K_out, bus.ir_ld, bus.halted, bus.retired_count}
            !== {32'd0, 2'd0, SAFE, 64'd0, 1'b0, 1'b0, 32'd0}) begin
            n_err++;
            $display("FAIL async_reset: I=%h ph=%0d cw=%h K=%h halted=%b ret=%0d want reset values",
                     bus.I_out, bus.phase, bus.cw_out, bus.K_out, bus.halted, bus.retired_count);
        end
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        for (int c = 0; c < 5; c++) begin
            for (int p = 0; p < 4; p++) begin
                cw_tab[c][p] = 33'd0;
                k_tab[c][p]  = 64'd0;
            end
        end
        bus.run = 1'b0; bus.mem_ready = 1'b0; bus.databus = 32'd0;
        test_reset();
        test_br();
        test_ldur_stall();
        test_exec_fault();
        test_fetch_timeout();
        test_run_low();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
